vend_dispenser: RTL
===================

# vend_dispenser

Output stage behind the vending FSM. Consumes its `purchase` / `cash_return` pulses and drives the physical product motor and change hopper through sense-acknowledged handshakes. Queues purchases that arrive while a previous dispense is still in progress, and flags mechanism faults. Sits between the vending FSM and the mechanism I/O.

## Interface
Parameters:
- `DEPTH`, 4: pending-event queue depth; power of two, ≥2.
- `TIMEOUT`, 1000: maximum cycles to wait for a sense input before declaring a fault.
- `PULSE_LEN`, 4: `coin_eject` high time in cycles, ≥1.

Ports:
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high; one clock, one reset.
- `purchase`  in  1  single-cycle purchase pulse from the vending FSM.
- `cash_return`  in  2  change owed with `purchase`, in coins; 00 = none, 01 = one coin, 10/11 = 2/3 coins.
- `item_sensed`  in  1  product-drop sensor; level, sampled only in VEND.
- `coin_sensed`  in  1  hopper exit sensor; sampled only in WAIT_COIN.
- `motor_on`  out  1  product motor drive.
- `coin_eject`  out  1  hopper solenoid pulse.
- `busy`  out  1  queue non-empty or FSM not IDLE.
- `overflow`  out  1  sticky; a purchase was dropped because the queue was full.
- `fault`  out  1  sticky; a sense timeout occurred.
- `vend_count`  out  16  number of completed product drops; wraps at 2^16.

## Operation
- **Push:** `purchase`=1 pushes `{cash_return}` into the queue. `cash_return` with `purchase`=0 is ignored.
- **Full queue:** the push is dropped and `overflow` is set. A push and a pop in the same cycle on a full queue is accepted.
- **States:** IDLE, VEND, EJECT, WAIT_COIN, FAULT.
- **IDLE:** if the queue is non-empty, load `coins` from the head entry and go to VEND.
- **VEND:** `motor_on`=1. On `item_sensed`: increment `vend_count`, then go to EJECT if `coins`>0; otherwise pop the head and return to IDLE.
- **EJECT:** `coin_eject`=1 for exactly `PULSE_LEN` cycles, then go to WAIT_COIN.
- **WAIT_COIN:** on `coin_sensed`, decrement `coins`. If the result is >0, go to EJECT; otherwise pop the head and return to IDLE.
- **Timeout:** a counter of width clog2(`TIMEOUT`) clears on entry to VEND or WAIT_COIN. If `TIMEOUT` cycles elapse in either state without a sense, go to FAULT.
- **FAULT:** `fault`=1, `motor_on`=`coin_eject`=0, entered only from a timeout. Exit only by `reset`. The queue still accepts pushes, and `overflow` still updates.
- **Sense filtering:** a sense input outside its sampling state has no effect.

## Timing
- **Reset values:** all outputs 0, queue empty, state IDLE, counters 0. Reset mid-dispense aborts immediately, with no further motor or eject activity.
- **Output registering:** outputs are registered and decoded from state.
- **Push latency:** `purchase` sampled high at edge E, queue non-empty after E. VEND is entered at E+1, so `motor_on` is high from E+1 to the edge after `item_sensed` is sampled.
- **Sense response:** a sense high at edge S moves the state at S, so the output drops in the next cycle.
- **Coin pacing:** minimum per coin is `PULSE_LEN` cycles of eject plus 1 sense cycle.
- **Back-to-back events:** a queued next event enters VEND one cycle after returning to IDLE. IDLE lasts exactly one cycle.
- **Timeout boundary:** a sense arriving in the same cycle the timeout expires wins; no fault is raised.

## Structure
- Package `vend_pkg` holds:
  - the state enum;
  - the `cash_return` code constants (`CR_NONE`=00, `CR_ONE`=01);
  - the `vend_count` width constant.
  
  These constants are shared with the vending FSM.
- Sub-module `vend_event_fifo`: synchronous FIFO, `DEPTH` × 2 bits, with push/pop/full/empty and registered pointers of width clog2(`DEPTH`)+1 for full/empty wrap detection.
- Top level holds the FSM, `coins` down-counter, timeout counter, pulse counter and sticky flags.

## Test plan
- **Single purchase, no change:** `purchase`=1 with `cash_return`=00, `item_sensed` 5 cycles after `motor_on` rises → `motor_on` high 6 cycles, no `coin_eject`, `vend_count`=1, `busy` falls.
- **Purchase with one coin:** `purchase` with `cash_return`=01, sense item, then `coin_sensed` 3 cycles after eject ends → exactly one 4-cycle `coin_eject` pulse, `vend_count`=1.
- **Queue fill:** 5 purchases on consecutive cycles with `DEPTH`=4, all sensed promptly → 4 vends complete, `overflow`=1, `vend_count`=4.
- **Item timeout:** withhold `item_sensed` → `fault`=1 at `TIMEOUT` cycles after VEND entry, `motor_on`=0. A later `item_sensed` is ignored; `reset` clears everything.
- **Boundary race:** `coin_sensed` arrives exactly on the timeout cycle → no fault, dispense completes.
- **Reset mid-eject:** assert `reset` during `coin_eject` → the next cycle has all outputs 0 and an empty queue; a new `purchase` then dispenses normally.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and constants for the dispenser output stage and the vending FSM.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_VEND      = 3'd1,
        S_EJECT     = 3'd2,
        S_WAIT_COIN = 3'd3,
        S_FAULT     = 3'd4
    } vend_state_t;

    localparam logic [1:0] CR_NONE = 2'b00;
    localparam logic [1:0] CR_ONE  = 2'b01;

    localparam int VCNT_W = 16;

endpackage

// File: rtl/vend_event_fifo.sv
// Pending-event queue: DEPTH entries of cash_return, extra pointer bit tells full from empty.
module vend_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_q, rd_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         push_ok, pop_ok;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign dout_o  = mem_q[rd_q[AW-1:0]];

    // A full queue still takes a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + (AW+1)'(1);
            if (pop_ok)  rd_q <= rd_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/vend_dispenser.sv
// Drives product motor and change hopper from queued purchase events, with sense timeouts.
import vend_pkg::*;

module vend_dispenser #(
    parameter int DEPTH     = 4,
    parameter int TIMEOUT   = 1000,
    parameter int PULSE_LEN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              purchase,
    input  logic [1:0]        cash_return,
    input  logic              item_sensed,
    input  logic              coin_sensed,
    output logic              motor_on,
    output logic              coin_eject,
    output logic              busy,
    output logic              overflow,
    output logic              fault,
    output logic [VCNT_W-1:0] vend_count
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int PW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0] PMAX = PW'(PULSE_LEN - 1);

    vend_state_t       state_q, state_d;
    logic [1:0]        coins_q;
    logic [TW-1:0]     tmr_q;
    logic [PW-1:0]     pcnt_q;
    logic              motor_on_q, coin_eject_q, overflow_q, fault_q;
    logic [VCNT_W-1:0] vend_count_q;

    logic              pop, fifo_full, fifo_empty;
    logic [1:0]        fifo_head;

    vend_event_fifo #(.DEPTH(DEPTH), .W(2)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (purchase),
        .pop_i   (pop),
        .din_i   (cash_return),
        .dout_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A sense on the timeout cycle takes priority over the fault.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE:      if (!fifo_empty) state_d = S_VEND;
            S_VEND: begin
                if (item_sensed) begin
                    if (coins_q != CR_NONE) state_d = S_EJECT;
                    else begin
                        state_d = S_IDLE;
                        pop     = 1'b1;
                    end
                end else if (tmr_q == TMAX) state_d = S_FAULT;
            end
            S_EJECT:     if (pcnt_q == PMAX) state_d = S_WAIT_COIN;
            S_WAIT_COIN: begin
                if (coin_sensed) begin
                    if (coins_q != CR_ONE) state_d = S_EJECT;
                    else begin
                        state_d = S_IDLE;
                        pop     = 1'b1;
                    end
                end else if (tmr_q == TMAX) state_d = S_FAULT;
            end
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            coins_q      <= '0;
            tmr_q        <= '0;
            pcnt_q       <= '0;
            motor_on_q   <= 1'b0;
            coin_eject_q <= 1'b0;
            overflow_q   <= 1'b0;
            fault_q      <= 1'b0;
            vend_count_q <= '0;
        end else begin
            state_q      <= state_d;
            motor_on_q   <= (state_d == S_VEND);
            coin_eject_q <= (state_d == S_EJECT);
            fault_q      <= fault_q | (state_d == S_FAULT);
            if (purchase && fifo_full && !pop) overflow_q <= 1'b1;

            if (state_q == S_IDLE && !fifo_empty) coins_q <= fifo_head;
            else if (state_q == S_WAIT_COIN && coin_sensed) coins_q <= coins_q - 2'd1;

            if (state_q == S_VEND && item_sensed) vend_count_q <= vend_count_q + VCNT_W'(1);

            if (state_d != state_q) tmr_q <= '0;
            else if (state_q == S_VEND || state_q == S_WAIT_COIN) tmr_q <= tmr_q + TW'(1);

            pcnt_q <= (state_q == S_EJECT && state_d == S_EJECT) ? pcnt_q + PW'(1) : '0;
        end
    end

    assign motor_on   = motor_on_q;
    assign coin_eject = coin_eject_q;
    assign overflow   = overflow_q;
    assign fault      = fault_q;
    assign vend_count = vend_count_q;
    assign busy       = (state_q != S_IDLE) || !fifo_empty;

endmodule
